// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch FSM state encoding.
package riscv_pkg;
  localparam int          DEF_BUS_WIDTH    = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_RESP = 2'd2,
    HOLD      = 2'd3
  } fetch_state_t;

  function automatic logic word_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction
endpackage

// File: rtl/next_pc_sel.sv
// Next-PC candidates: sequential pc+4 and the redirect target with alignment handling.
// MISALIGN_TRAP_EN: misaligned targets are dropped and flagged instead of being truncated.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
) (
  input  logic [BUS_WIDTH-1:0] pc_i,
  input  logic                 br_taken_i,
  input  logic [BUS_WIDTH-1:0] br_target_i,
  output logic [BUS_WIDTH-1:0] seq_pc_o,
  output logic                 redir_o,
  output logic [BUS_WIDTH-1:0] redir_pc_o,
  output logic                 misalign_o
);
  // Natural wrap of the adder gives the modulo-2^BUS_WIDTH increment.
  assign seq_pc_o = pc_i + BUS_WIDTH'(4);

`ifdef MISALIGN_TRAP_EN
  assign redir_o    = br_taken_i && word_aligned(br_target_i[1:0]);
  assign misalign_o = br_taken_i && !word_aligned(br_target_i[1:0]);
  assign redir_pc_o = br_target_i;
`else
  assign redir_o    = br_taken_i;
  assign misalign_o = 1'b0;
  assign redir_pc_o = br_target_i & ~BUS_WIDTH'(3);
`endif
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: request/grant/response FSM with redirect and kill handling.
// Optional MISALIGN_TRAP_EN (see next_pc_sel) turns misaligned redirects into a misalign_o pulse.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int                   BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 br_taken_i,
  input  logic [BUS_WIDTH-1:0] br_target_i,
  output logic                 imem_req_o,
  output logic [BUS_WIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [INSTR_W-1:0]   imem_rdata_i,
  output logic [INSTR_W-1:0]   instr_o,
  output logic [BUS_WIDTH-1:0] instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic                 misalign_o
);
  fetch_state_t         state_q;
  logic [BUS_WIDTH-1:0] pc_q, ipc_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 kill_q, req_q, vld_q, mis_q;

  logic [BUS_WIDTH-1:0] seq_pc, redir_pc;
  logic                 redir, mis;

  next_pc_sel #(.BUS_WIDTH(BUS_WIDTH)) u_next_pc_sel (
    .pc_i        (pc_q),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .seq_pc_o    (seq_pc),
    .redir_o     (redir),
    .redir_pc_o  (redir_pc),
    .misalign_o  (mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      ipc_q   <= '0;
      instr_q <= '0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= mis && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (redir) pc_q <= redir_pc;
          // A redirect in the grant cycle means the in-flight response is stale.
          if (imem_gnt_i) begin
            state_q <= WAIT_RESP;
            req_q   <= 1'b0;
            kill_q  <= redir;
          end
        end
        WAIT_RESP: begin
          if (redir) pc_q <= redir_pc;
          if (imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (kill_q || redir) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end else begin
              instr_q <= imem_rdata_i;
              ipc_q   <= pc_q;
              vld_q   <= 1'b1;
              state_q <= HOLD;
            end
          end else if (redir) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redir || instr_ready_i) begin
            pc_q    <= redir ? redir_pc : seq_pc;
            vld_q   <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = vld_q;
  assign misalign_o    = mis_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: bench-side memory, scoreboard of expected {pc, instr}.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check its address, grant it, return the response.
  task automatic serve(input logic [31:0] a);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    chk("req_drop_after_gnt", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = mem(a);
    sb.push_back('{pc: a, ins: mem(a)});
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic expect_instr();
    exp_t e;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("instr_pc", instr_pc, e.pc);
      chk("instr", instr, e.ins);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Sequential fetches 0x0, 0x4, 0x8 with immediate gnt/rvalid.
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      serve(32'(i * 4));
      if (i == 2) instr_ready = 1'b0;
      expect_instr();
    end

    // Stall in HOLD: outputs stable, no new request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_pc", instr_pc, 32'h8);
      chk("hold_instr", instr, mem(32'h8));
      chk("hold_no_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("accept_req", {31'd0, imem_req}, 32'd1);
    chk("accept_addr", imem_addr, 32'hC);

    // Redirect during WAIT_RESP: stale response for 0xC must be dropped.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h100;
    @(negedge clk);
    br_taken    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem(32'hC);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("kill_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("kill_refetch_req", {31'd0, imem_req}, 32'd1);
    chk("kill_refetch_addr", imem_addr, 32'h100);
    serve(32'h100);
    expect_instr();

    // Redirect in FETCH to the top word, then the increment wraps to 0.
    @(negedge clk);
    chk("pre_wrap_addr", imem_addr, 32'h104);
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    br_taken = 1'b0;
    serve(32'hFFFF_FFFC);
    expect_instr();
    serve(32'h0);
    instr_ready = 1'b0;
    expect_instr();

    // Misaligned redirect from HOLD.
    br_taken  = 1'b1;
    br_target = 32'h102;
    @(negedge clk);
    br_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_still_valid", {31'd0, instr_valid}, 32'd1);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    serve(32'h4);
`else
    chk("mis_tied", {31'd0, misalign}, 32'd0);
    chk("mis_trunc_valid", {31'd0, instr_valid}, 32'd0);
    chk("mis_trunc_addr", imem_addr, 32'h100);
    instr_ready = 1'b1;
    serve(32'h100);
`endif
    expect_instr();

    // Asynchronous reset in the middle of WAIT_RESP.
    @(negedge clk);
    serve_grant_only();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_instr_pc", instr_pc, 32'd0);
    chk("arst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    serve(32'h0);
    expect_instr();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Grant a pending request and leave the DUT waiting for its response.
  task automatic serve_grant_only();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arst_req_seen", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
  endtask
endmodule
